instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Drives the loadable program counter and instruction memory to fetch variable-length
//   instructions (1 opcode byte + 0..2 operand bytes) and hands each complete instruction
//   to the decoder over a valid/ready handshake. Accepts jump requests from the decoder
//   and loads the PC target in a single cycle. Sits between program counter, memory, decoder.
// PARAMETERS
//   ADDR_WIDTH  16  PC / memory address width
//   DATA_WIDTH  8   memory byte width; operand is 2*DATA_WIDTH
// PORTS
//   clock          in   1     system clock, all logic on rising edge
//   reset          in   1     synchronous reset, active high
//   pc_count       in   ADDR  current program counter value
//   pc_increment   out  1     advance PC by one at next edge
//   pc_set         out  1     load pc_new_count into PC at next edge
//   pc_new_count   out  ADDR  jump target for PC
//   mem_addr       out  ADDR  read address (= pc_count, combinational)
//   mem_read       out  1     read strobe; data returned on mem_data one cycle later
//   mem_data       in   DATA  read data for address presented previous cycle
//   jump_req       in   1     decoder requests jump (level, held until jump_ack)
//   jump_target    in   ADDR  jump destination, valid with jump_req
//   jump_ack       out  1     jump taken this cycle (= pc_set)
//   instr_valid    out  1     complete instruction presented
//   instr_ready    in   1     decoder accepts instruction
//   instr_opcode   out  DATA  opcode byte
//   instr_operand  out  2*DATA operand; {0,lo} for 1 byte, {hi,lo} for 2, 0 for none
//   instr_length   out  2     operand byte count 0..2
//   instr_addr     out  ADDR  address of opcode byte
// BEHAVIOUR
// - States: OP_ISSUE, OP_CAPTURE, LO_ISSUE, LO_CAPTURE, HI_ISSUE, HI_CAPTURE, PRESENT.
// - Reset: state<=OP_ISSUE; instr_valid, pc_increment, pc_set, jump_ack, mem_read =0;
//   opcode/operand/length/addr regs =0. Block never resets the PC itself.
//   Reset mid-fetch discards partial bytes; reset beats jump_req (no pc_set during reset).
// - *_ISSUE: mem_read=1, pc_increment=1; OP_ISSUE also latches instr_addr<=pc_count.
// - *_CAPTURE: latch mem_data into opcode/lo/hi. Operand count from opcode[7:6]:
//   00->0, 01->1, 1x->2. OP_CAPTURE -> PRESENT (0), else LO_ISSUE; LO_CAPTURE ->
//   PRESENT (1) or HI_ISSUE (2); HI_CAPTURE -> PRESENT. Operand regs cleared in OP_CAPTURE.
// - Latency: 2 cycles per byte; instr_valid asserts in cycle 2*(1+len) after OP_ISSUE.
// - PRESENT: instr_valid=1, outputs stable, pc_increment=0, no memory reads until
//   instr_valid&instr_ready; then -> OP_ISSUE (next fetch starts next cycle).
// - Jump: when jump_req=1 and reset=0, in ANY state: pc_set=jump_ack=1 for that cycle,
//   pc_new_count=jump_target, pc_increment=0, mem_read=0; next state OP_ISSUE; any
//   partially fetched bytes discarded; a PRESENT instruction not handshaken this cycle is
//   dropped (instr_valid=0 next cycle). Handshake in same cycle as jump: instruction counts
//   as consumed. pc_set and pc_increment never both high.
// - Address wrap: PC wraps 0xFFFF->0x0000 (PC arithmetic); fetch continues across wrap.
// - pc_new_count = jump_target when pc_set, else 0.
// TESTING
// 1. mem[0]=0x05, release reset -> cycle 2: instr_valid, opcode 0x05, len 0, addr 0x0000, pc 1.
// 2. mem[0..2]=85,34,12 -> after 6 cycles: opcode 0x85, operand 0x1234, len 2; pc 3.
// 3. mem[0..1]=45,7A, instr_ready low 5 cycles -> valid/outputs held, operand 0x007A,
//    no pc_increment/mem_read while stalled; accept -> fetch resumes at 0x0002.
// 4. jump_req target 0x4000 during LO_CAPTURE -> pc_set/jump_ack 1 cycle, partial dropped,
//    next instr_addr 0x4000.
// 5. jump_req with instr_valid&instr_ready in PRESENT -> consumed once, pc loads target;
//    reset asserted in HI_ISSUE -> no valid, restarts in OP_ISSUE.
// 6. pc=0xFFFF, mem[FFFF,0000,0001]=C1,EF,BE -> operand 0xBEEF, addr 0xFFFF, pc 0x0002.

Source files
------------

// File: rtl/instruction_fetch.sv
// Variable-length instruction fetch: drives PC and memory strobes, assembles opcode plus
// 0..2 operand bytes, and presents each instruction to the decoder over valid/ready.
//
// state      | meaning
// OP_ISSUE   | read opcode byte at PC, advance PC, remember opcode address
// OP_CAPTURE | latch opcode, derive operand count, clear operand bytes
// LO_ISSUE   | read low operand byte, advance PC
// LO_CAPTURE | latch low operand byte
// HI_ISSUE   | read high operand byte, advance PC
// HI_CAPTURE | latch high operand byte
// PRESENT    | instruction held on outputs until decoder accepts it
module instruction_fetch #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   pc_count,
  output logic                    pc_increment,
  output logic                    pc_set,
  output logic [ADDR_WIDTH-1:0]   pc_new_count,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_read,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  input  logic                    jump_req,
  input  logic [ADDR_WIDTH-1:0]   jump_target,
  output logic                    jump_ack,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [DATA_WIDTH-1:0]   instr_opcode,
  output logic [2*DATA_WIDTH-1:0] instr_operand,
  output logic [1:0]              instr_length,
  output logic [ADDR_WIDTH-1:0]   instr_addr
);

  typedef enum logic [2:0] {
    OP_ISSUE   = 3'd0,
    OP_CAPTURE = 3'd1,
    LO_ISSUE   = 3'd2,
    LO_CAPTURE = 3'd3,
    HI_ISSUE   = 3'd4,
    HI_CAPTURE = 3'd5,
    PRESENT    = 3'd6
  } state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   opcode_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic [DATA_WIDTH-1:0]   hi_q;
  logic [1:0]              length_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              fetched_len;

  // Operand count lives in the two top opcode bits: 00 -> 0, 01 -> 1, 1x -> 2.
  always_comb begin
    fetched_len = 2'd0;
    if (mem_data[DATA_WIDTH-1])
      fetched_len = 2'd2;
    else if (mem_data[DATA_WIDTH-2])
      fetched_len = 2'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= OP_ISSUE;
      opcode_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      length_q <= 2'd0;
      addr_q   <= '0;
    end else begin
      state <= state_next;
      if (!jump_req) begin
        case (state)
          OP_ISSUE: addr_q <= pc_count;
          OP_CAPTURE: begin
            opcode_q <= mem_data;
            length_q <= fetched_len;
            lo_q     <= '0;
            hi_q     <= '0;
          end
          LO_CAPTURE: lo_q <= mem_data;
          HI_CAPTURE: hi_q <= mem_data;
          default: ;
        endcase
      end
    end
  end

  // Reset gates every strobe so a synchronous reset wins over a pending jump.
  always_comb begin
    state_next   = state;
    pc_increment = 1'b0;
    pc_set       = 1'b0;
    mem_read     = 1'b0;
    instr_valid  = 1'b0;
    if (!reset) begin
      instr_valid = (state == PRESENT);
      if (jump_req) begin
        pc_set     = 1'b1;
        state_next = OP_ISSUE;
      end else begin
        case (state)
          OP_ISSUE, LO_ISSUE, HI_ISSUE: begin
            mem_read     = 1'b1;
            pc_increment = 1'b1;
            state_next   = state_t'(state + 3'd1);
          end
          OP_CAPTURE:
            state_next = (fetched_len == 2'd0) ? PRESENT : LO_ISSUE;
          LO_CAPTURE:
            state_next = (length_q == 2'd1) ? PRESENT : HI_ISSUE;
          HI_CAPTURE:
            state_next = PRESENT;
          PRESENT:
            if (instr_ready) state_next = OP_ISSUE;
          default:
            state_next = OP_ISSUE;
        endcase
      end
    end
  end

  assign jump_ack      = pc_set;
  assign pc_new_count  = pc_set ? jump_target : '0;
  assign mem_addr      = pc_count;
  assign instr_opcode  = opcode_q;
  assign instr_operand = {hi_q, lo_q};
  assign instr_length  = length_q;
  assign instr_addr    = addr_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: models PC and byte memory around the DUT and checks every
// presented instruction against a reference decoded straight from memory contents.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        pc_increment, pc_set, mem_read, jump_ack, instr_valid;
  logic [15:0] pc_new_count, mem_addr, instr_addr, instr_operand;
  logic [7:0]  mem_data, instr_opcode;
  logic        jump_req, instr_ready;
  logic [15:0] jump_target;
  logic [1:0]  instr_length;

  logic [7:0]  mem [0:65535];
  logic        pc_preset_en;
  logic [15:0] pc_preset_val;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clock = ~clock;

  instruction_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .pc_count(pc), .pc_increment(pc_increment),
    .pc_set(pc_set), .pc_new_count(pc_new_count), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_data(mem_data), .jump_req(jump_req),
    .jump_target(jump_target), .jump_ack(jump_ack), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_operand(instr_operand), .instr_length(instr_length), .instr_addr(instr_addr)
  );

  // Environment: loadable PC and a memory returning data one cycle after the strobe.
  always @(posedge clock) begin
    if (pc_preset_en)      pc <= pc_preset_val;
    else if (pc_set)       pc <= pc_new_count;
    else if (pc_increment) pc <= pc + 16'd1;
    if (mem_read) mem_data <= mem[mem_addr];
  end

  function automatic int op_len(input logic [7:0] op);
    return op[7] ? 2 : (op[6] ? 1 : 0);
  endfunction

  task automatic start_at(input logic [15:0] a);
    reset = 1'b1; jump_req = 1'b0; instr_ready = 1'b0; jump_target = 16'h0;
    pc_preset_val = a; pc_preset_en = 1'b1;
    @(negedge clock); @(negedge clock);
    pc_preset_en = 1'b0; reset = 1'b0;
    #1;
  endtask

  // Entered in an OP_ISSUE cycle; leaves in the OP_ISSUE cycle of the following fetch.
  task automatic do_fetch(input logic [15:0] a, input int stall, output logic [15:0] nxt);
    logic [7:0]  op;
    logic [15:0] opd;
    int          len, k;
    op  = mem[a];
    len = op_len(op);
    opd = (len == 0) ? 16'h0 : (len == 1) ? {8'h00, mem[a + 16'd1]}
                                          : {mem[a + 16'd2], mem[a + 16'd1]};
    nxt = a + 16'(1 + len);
    k = 0;
    while (!instr_valid && k < 20) begin @(negedge clock); #1; k++; end
    vectors++;
    if (k != 2 * (1 + len)) begin
      miscompares++;
      $display("FAIL latency @%h: got %0d cycles, want %0d", a, k, 2 * (1 + len));
    end
    vectors++;
    if ({instr_opcode, instr_operand, instr_length, instr_addr} !== {op, opd, 2'(len), a}) begin
      miscompares++;
      $display("FAIL fields @%h: got op=%h opd=%h len=%0d addr=%h, want op=%h opd=%h len=%0d addr=%h",
               a, instr_opcode, instr_operand, instr_length, instr_addr, op, opd, len, a);
    end
    vectors++;
    if (pc !== nxt) begin
      miscompares++;
      $display("FAIL pc_after_fetch @%h: got %h, want %h", a, pc, nxt);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clock); #1;
      vectors++;
      if (instr_valid !== 1'b1 || instr_opcode !== op || instr_operand !== opd ||
          instr_addr !== a || pc_increment !== 1'b0 || mem_read !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold @%h: got valid=%b op=%h opd=%h inc=%b rd=%b, want 1 %h %h 0 0",
                 a, instr_valid, instr_opcode, instr_operand, pc_increment, mem_read, op, opd);
      end
    end
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || mem_read !== 1'b1 || mem_addr !== nxt) begin
      miscompares++;
      $display("FAIL accept @%h: got valid=%b rd=%b addr=%h, want 0 1 %h",
               a, instr_valid, mem_read, mem_addr, nxt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; jump_req = 1'b1; jump_target = 16'h1234; instr_ready = 1'b0;
    pc_preset_en = 1'b1; pc_preset_val = 16'h0;
    repeat (3) @(negedge clock);
    #1;
    vectors++;
    if ({instr_valid, pc_increment, pc_set, jump_ack, mem_read} !== 5'b0 ||
        {instr_opcode, instr_operand, instr_length, instr_addr} !== 42'h0 ||
        pc_new_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b inc=%b set=%b ack=%b rd=%b op=%h opd=%h len=%0d addr=%h",
               instr_valid, pc_increment, pc_set, jump_ack, mem_read, instr_opcode,
               instr_operand, instr_length, instr_addr);
    end
    jump_req = 1'b0;
    pc_preset_en = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] n;
    mem[0] = 8'h05;
    start_at(16'h0000);
    do_fetch(16'h0000, 0, n);
    mem[0] = 8'h85; mem[1] = 8'h34; mem[2] = 8'h12;
    start_at(16'h0000);
    do_fetch(16'h0000, 0, n);
  endtask

  task automatic test_stall();
    logic [15:0] n;
    mem[0] = 8'h45; mem[1] = 8'h7A; mem[2] = 8'h3C;
    start_at(16'h0000);
    do_fetch(16'h0000, 5, n);
    do_fetch(n, 2, n);
  endtask

  task automatic test_jump_mid_fetch();
    logic [15:0] n;
    mem[16'h0100] = 8'h85; mem[16'h0101] = 8'h11; mem[16'h0102] = 8'h22;
    mem[16'h4000] = 8'h4C; mem[16'h4001] = 8'h99;
    start_at(16'h0100);
    repeat (3) @(negedge clock);
    jump_req = 1'b1; jump_target = 16'h4000;
    #1;
    vectors++;
    if (pc_set !== 1'b1 || jump_ack !== 1'b1 || pc_new_count !== 16'h4000 ||
        pc_increment !== 1'b0 || mem_read !== 1'b0 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_cycle: got set=%b ack=%b new=%h inc=%b rd=%b v=%b, want 1 1 4000 0 0 0",
               pc_set, jump_ack, pc_new_count, pc_increment, mem_read, instr_valid);
    end
    @(negedge clock);
    jump_req = 1'b0;
    #1;
    vectors++;
    if (pc_set !== 1'b0 || jump_ack !== 1'b0 || pc_new_count !== 16'h0 ||
        instr_valid !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 16'h4000) begin
      miscompares++;
      $display("FAIL jump_after: got set=%b ack=%b new=%h v=%b rd=%b addr=%h, want 0 0 0000 0 1 4000",
               pc_set, jump_ack, pc_new_count, instr_valid, mem_read, mem_addr);
    end
    do_fetch(16'h4000, 0, n);
  endtask

  task automatic test_jump_present(input logic take);
    logic [15:0] n, tgt;
    tgt = take ? 16'h5000 : 16'h6000;
    mem[16'h0200] = 8'h07;
    mem[tgt] = 8'h43; mem[tgt + 16'd1] = 8'h55;
    start_at(16'h0200);
    repeat (2) @(negedge clock);
    instr_ready = take; jump_req = 1'b1; jump_target = tgt;
    #1;
    vectors++;
    if (instr_valid !== 1'b1 || pc_set !== 1'b1 || pc_increment !== 1'b0 ||
        instr_opcode !== 8'h07 || instr_addr !== 16'h0200) begin
      miscompares++;
      $display("FAIL jump_present(take=%b): got v=%b set=%b inc=%b op=%h addr=%h, want 1 1 0 07 0200",
               take, instr_valid, pc_set, pc_increment, instr_opcode, instr_addr);
    end
    @(negedge clock);
    instr_ready = 1'b0; jump_req = 1'b0;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || mem_read !== 1'b1 || mem_addr !== tgt) begin
      miscompares++;
      $display("FAIL jump_present_after(take=%b): got v=%b rd=%b addr=%h, want 0 1 %h",
               take, instr_valid, mem_read, mem_addr, tgt);
    end
    do_fetch(tgt, 1, n);
  endtask

  task automatic test_reset_mid_fetch();
    logic [15:0] n;
    mem[16'h0400] = 8'h9A; mem[16'h0401] = 8'h01; mem[16'h0402] = 8'h3F;
    start_at(16'h0400);
    repeat (4) @(negedge clock);
    #1;
    vectors++;
    if (mem_read !== 1'b1 || pc_increment !== 1'b1 || mem_addr !== 16'h0402) begin
      miscompares++;
      $display("FAIL hi_issue: got rd=%b inc=%b addr=%h, want 1 1 0402", mem_read, pc_increment, mem_addr);
    end
    reset = 1'b1; jump_req = 1'b1; jump_target = 16'h7777;
    #1;
    vectors++;
    if ({pc_set, jump_ack, mem_read, pc_increment, instr_valid} !== 5'b0 || pc_new_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_beats_jump: got set=%b ack=%b rd=%b inc=%b v=%b new=%h, want all 0",
               pc_set, jump_ack, mem_read, pc_increment, instr_valid, pc_new_count);
    end
    @(negedge clock);
    reset = 1'b0; jump_req = 1'b0;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 16'h0402 || instr_opcode !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_restart: got v=%b rd=%b addr=%h op=%h, want 0 1 0402 00",
               instr_valid, mem_read, mem_addr, instr_opcode);
    end
    do_fetch(16'h0402, 0, n);
  endtask

  task automatic test_wrap();
    logic [15:0] n;
    mem[16'hFFFF] = 8'hC1; mem[16'h0000] = 8'hEF; mem[16'h0001] = 8'hBE; mem[16'h0002] = 8'h40;
    mem[16'h0003] = 8'h6E;
    start_at(16'hFFFF);
    do_fetch(16'hFFFF, 0, n);
    do_fetch(n, 0, n);
  endtask

  task automatic test_random();
    logic [15:0] a;
    a = 16'($urandom);
    for (int i = 0; i < 200; i++) mem[a + 16'(i)] = 8'($urandom);
    start_at(a);
    for (int i = 0; i < 30; i++) do_fetch(a, int'($urandom_range(0, 3)), a);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset = 1'b1; jump_req = 1'b0; jump_target = 16'h0; instr_ready = 1'b0;
    pc_preset_en = 1'b1; pc_preset_val = 16'h0;
    test_reset();
    test_basic();
    test_stall();
    test_jump_mid_fetch();
    test_jump_present(1'b1);
    test_jump_present(1'b0);
    test_reset_mid_fetch();
    test_wrap();
    for (int r = 0; r < 4; r++) test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
